// File: rtl/nios2_oci_dct_packer_pkg.sv
// Shared constants, FSM state encoding and packet record for the OCI trace packer.
package nios2_oci_dct_pkg;

  localparam int ATOM_W = 2;
  localparam int DEPTH  = 15;
  localparam int BUF_W  = ATOM_W * DEPTH;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    FILL,
    FLUSH,
    DRAIN,
    ENDED
  } dct_state_e;

  typedef struct packed {
    logic [BUF_W-1:0] data;
    logic [CNT_W-1:0] count;
  } dct_pkt_t;

  // Newest atom enters at the LSBs; the oldest migrates toward the MSBs.
  function automatic logic [BUF_W-1:0] shift_in(input logic [BUF_W-1:0] buf_q,
                                                input logic [ATOM_W-1:0] atom);
    return {buf_q[BUF_W-ATOM_W-1:0], atom};
  endfunction

endpackage

// File: rtl/nios2_oci_dct_packer_if.sv
// Atom input and packet output handshakes of the trace packer; slave = packer side.
interface nios2_oci_dct_packer_if;
  import nios2_oci_dct_pkg::*;

  logic              atom_valid;
  logic [ATOM_W-1:0] atom_data;
  logic              atom_ready;
  logic              pkt_valid;
  logic [BUF_W-1:0]  pkt_data;
  logic [CNT_W-1:0]  pkt_count;
  logic              pkt_ready;

  modport master (
    output atom_valid, atom_data, pkt_ready,
    input  atom_ready, pkt_valid, pkt_data, pkt_count
  );

  modport slave (
    input  atom_valid, atom_data, pkt_ready,
    output atom_ready, pkt_valid, pkt_data, pkt_count
  );

endinterface

// File: rtl/nios2_oci_dct_packer_outreg.sv
// One-entry valid/ready output register; 'free' means a load may happen this cycle.
module nios2_oci_dct_outreg
  import nios2_oci_dct_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     load,
  input  dct_pkt_t load_pkt,
  input  logic     pkt_ready,
  output logic     free,
  output logic     pkt_valid,
  output dct_pkt_t pkt
);

  assign free = !pkt_valid || pkt_ready;

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  // The payload is reset as well so the packet port reads 0 straight after reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pkt_valid <= 1'b0;
      pkt       <= '0;
    end else if (load) begin
      pkt_valid <= 1'b1;
      pkt       <= load_pkt;
    end else if (pkt_ready) begin
      pkt_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-atom packets and sequences the end-of-test flush.
// Build option DCT_DROP_COUNT_EN: never stall in FILL, drop and count excess atoms.
module nios2_oci_dct_packer
  import nios2_oci_dct_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  nios2_oci_dct_packer_if.slave  bus,
  input  logic                   test_ending,
  output logic [BUF_W-1:0]       dct_buffer,
  output logic [CNT_W-1:0]       dct_count,
  output logic                   test_has_ended
`ifdef DCT_DROP_COUNT_EN
  ,
  output logic [15:0]            drop_count
`endif
);

  dct_state_e state, state_nxt;
  logic       full;
  logic       out_free;
  logic       launch;
  logic       stall;
  logic       ready;
  logic       accept;
  dct_pkt_t   out_pkt;

  assign full = (dct_count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= FILL;
    else          state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    stall     = 1'b0;
    ready     = 1'b0;
    unique case (state)
      FILL: begin
        launch = full && out_free;
        stall  = full && !out_free;
`ifdef DCT_DROP_COUNT_EN
        ready  = 1'b1;
`else
        ready  = !stall;
`endif
        if (test_ending) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (dct_count == '0) begin
          state_nxt = ENDED;
        end else if (out_free) begin
          launch    = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.pkt_valid && bus.pkt_ready) state_nxt = ENDED;
      end
      ENDED: ;
      default: state_nxt = FILL;
    endcase
  end

  // A stalled atom is only ever acknowledged when the drop option holds ready high.
  assign accept         = bus.atom_valid && ready && !stall;
  assign bus.atom_ready = ready;
  assign test_has_ended = (state == ENDED);

  // A launch and an accept on the same edge start the next buffer with that atom.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dct_buffer <= '0;
      dct_count  <= '0;
    end else if (launch) begin
      dct_buffer <= accept ? BUF_W'(bus.atom_data) : '0;
      dct_count  <= accept ? CNT_W'(1) : '0;
    end else if (accept) begin
      dct_buffer <= shift_in(dct_buffer, bus.atom_data);
      dct_count  <= dct_count + CNT_W'(1);
    end
  end

`ifdef DCT_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n)                                     drop_count <= '0;
    else if (bus.atom_valid && stall && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end
`endif

  nios2_oci_dct_outreg u_outreg (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (launch),
    .load_pkt  ('{data: dct_buffer, count: dct_count}),
    .pkt_ready (bus.pkt_ready),
    .free      (out_free),
    .pkt_valid (bus.pkt_valid),
    .pkt       (out_pkt)
  );

  assign bus.pkt_data  = out_pkt.data;
  assign bus.pkt_count = out_pkt.count;

endmodule
